mult_arbiter: RTL

//  Round-robin controller sharing one sequential 8x8 multiplier among N_REQ requesters.
//  - Latches the winner's operands and issues a start to the multiplier.
//  - Tracks the multiplier's busy handshake and returns the product with a per-requester done pulse.
//  - A watchdog aborts the operation if the multiplier never responds.

---
 rtl/mult_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among N_REQ requesters,
// with operand latching, busy-handshake tracking and a watchdog abort.
module mult_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [N_REQ*W-1:0] a_bi,
   input  logic [N_REQ*W-1:0] b_bi,
   output logic [N_REQ-1:0]   gnt_o,
   output logic [N_REQ-1:0]   done_o,
   output logic               err_o,
   output logic [2*W-1:0]     y_bo,
   output logic               busy_o,
   output logic               mul_start_o,
   output logic [W-1:0]       mul_a_bo,
   output logic [W-1:0]       mul_b_bo,
   input  logic               mul_busy_i,
   input  logic [2*W-1:0]     mul_y_bi
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [PW:0] N_L = (PW+1)'(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [CW-1:0]      wd_q, wd_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
   logic               err_q, err_d, start_q, start_d;
   logic [2*W-1:0]     y_q, y_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;

   logic [2*N_REQ-1:0] req_rot;
   logic [PW-1:0]      off, win;
   logic [PW:0]        win_sum;
   logic               timeout;

   // Requests rotated so that bit 0 is the requester at the RR pointer.
   always_comb begin
      req_rot = {req_i, req_i} >> ptr_q;
      off     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) off = PW'(i);
      end
      win_sum = {1'b0, ptr_q} + {1'b0, off};
      if (win_sum >= N_L) win_sum = win_sum - N_L;
      win = win_sum[PW-1:0];
   end

   assign timeout = (wd_q == CW'(TIMEOUT - 1));

   // NOTE: every next-state variable is defaulted to its current value first,
   // so no path through the case statement can infer a latch.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      gnt_d   = gnt_q;
      done_d  = done_q;
      err_d   = err_q;
      start_d = start_q;
      y_d     = y_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         S_IDLE: begin
            wd_d = '0;
            if (|req_i) begin
               gnt_d = '0;
               for (int k = 0; k < N_REQ; k++) begin
                  if (win == PW'(k)) begin
                     gnt_d[k] = 1'b1;
                     a_d      = a_bi[k*W +: W];
                     b_d      = b_bi[k*W +: W];
                  end
               end
               ptr_d   = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
               start_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE, S_RUN: begin
            wd_d = wd_q + 1'b1;
            if (timeout) begin
               done_d  = gnt_q;
               err_d   = 1'b1;
               y_d     = '0;
               start_d = 1'b0;
               state_d = S_DONE;
            end else if (state_q == S_ISSUE && mul_busy_i) begin
               start_d = 1'b0;
               state_d = S_RUN;
            end else if (state_q == S_RUN && !mul_busy_i) begin
               y_d     = mul_y_bi;
               done_d  = gnt_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            gnt_d   = '0;
            done_d  = '0;
            err_d   = 1'b0;
            wd_d    = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled at the same edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         wd_q    <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         y_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         start_q <= start_d;
         y_q     <= y_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign y_bo        = y_q;
   assign busy_o      = (state_q != S_IDLE);
   assign mul_start_o = start_q;
   assign mul_a_bo    = a_q;
   assign mul_b_bo    = b_q;

endmodule
